// File: rtl/riscv_32i_defs_pkg.sv
// rtl/riscv_32i_defs_pkg.sv - shared RV32I widths, types and constants
package riscv_32i_defs_pkg;

    localparam int XLEN           = 32;
    localparam int NUM_REGS       = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [XLEN-1:0]           word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_file_intf.sv
// rtl/reg_file_intf.sv - signal bundle for rv32i_reg_file with monitor and driver views
interface reg_file_intf
    import riscv_32i_defs_pkg::*;
(
    input logic clk
);
    logic      rst;
    logic      wr_en;
    reg_addr_t wr_reg;
    word_t     wr_data;
    reg_addr_t rd_reg_1;
    reg_addr_t rd_reg_2;
    word_t     rd_data_1;
    word_t     rd_data_2;

    modport monitor (
        input clk, rst, wr_en, wr_reg, wr_data,
        input rd_reg_1, rd_reg_2, rd_data_1, rd_data_2
    );

    modport driver (
        input  clk, rd_data_1, rd_data_2,
        output rst, wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2
    );
endinterface

// File: rtl/reg_file_assert.sv
// rtl/reg_file_assert.sv - concurrent checks for rv32i_reg_file, bound into every instance
module reg_file_assert
    import riscv_32i_defs_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] rd_reg_1,
    input logic [ADDR_WIDTH-1:0] rd_reg_2,
    input logic [DATA_WIDTH-1:0] rd_data_1,
    input logic [DATA_WIDTH-1:0] rd_data_2
);
    // Remembers a reset that fired between edges, which the edge sampling alone misses.
    logic r_rst_seen;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rst_seen <= 1'b1;
        else     r_rst_seen <= 1'b0;
    end

    a_x0_rd_1: assert property (@(posedge clk) (rd_reg_1 == '0) |-> (rd_data_1 == '0));
    a_x0_rd_2: assert property (@(posedge clk) (rd_reg_2 == '0) |-> (rd_data_2 == '0));

    a_hold_rd_1: assert property (@(posedge clk)
        (!rst && !r_rst_seen && !wr_en && !$past(wr_en) && $stable(rd_reg_1)) |-> $stable(rd_data_1));
    a_hold_rd_2: assert property (@(posedge clk)
        (!rst && !r_rst_seen && !wr_en && !$past(wr_en) && $stable(rd_reg_2)) |-> $stable(rd_data_2));

    a_known: assert property (@(posedge clk) !rst |-> !$isunknown({rd_data_1, rd_data_2}));
endmodule

bind rv32i_reg_file reg_file_assert #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
) u_reg_file_assert (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_reg_1  (rd_reg_1),
    .rd_reg_2  (rd_reg_2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2)
);

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - one combinational read port; forwards wr_data when REG_FILE_WR_BYPASS_EN
module reg_file_rd_port
    import riscv_32i_defs_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_regs [NUM_REGS],
    input  logic [ADDR_WIDTH-1:0] i_rd_reg,
    input  logic                  i_wr_fire,
    input  logic [ADDR_WIDTH-1:0] i_wr_reg,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    logic w_rd_is_zero;
    assign w_rd_is_zero = (i_rd_reg == ADDR_WIDTH'(ZERO_REG));

`ifdef REG_FILE_WR_BYPASS_EN
    always_comb begin
        o_rd_data = '0;
        if (!w_rd_is_zero) begin
            if (i_wr_fire && (i_wr_reg == i_rd_reg))
                o_rd_data = i_wr_data;
            else
                o_rd_data = i_regs[i_rd_reg];
        end
    end
`else
    logic w_unused_wr;
    assign w_unused_wr = ^{i_wr_fire, i_wr_reg, i_wr_data};

    always_comb begin
        o_rd_data = '0;
        if (!w_rd_is_zero)
            o_rd_data = i_regs[i_rd_reg];
    end
`endif
endmodule

// File: rtl/rv32i_reg_file.sv
// rtl/rv32i_reg_file.sv - RV32I register file, 2R/1W, x0 hardwired; optional REG_FILE_WR_BYPASS_EN
module rv32i_reg_file
    import riscv_32i_defs_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_reg,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_reg_1,
    input  logic [ADDR_WIDTH-1:0] rd_reg_2,
    output logic [DATA_WIDTH-1:0] rd_data_1,
    output logic [DATA_WIDTH-1:0] rd_data_2
);
    logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic                  w_wr_fire;

    assign w_wr_fire = wr_en && !rst && (wr_reg != ADDR_WIDTH'(ZERO_REG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_fire) begin
            r_regs[wr_reg] <= wr_data;
        end
    end

    // x0 has no flops; the read mux sees a constant zero in slot 0.
    always_comb begin
        w_regs[0] = '0;
        for (int i = 1; i < NUM_REGS; i++)
            w_regs[i] = r_regs[i];
    end

    reg_file_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_port_1 (
        .i_regs    (w_regs),
        .i_rd_reg  (rd_reg_1),
        .i_wr_fire (w_wr_fire),
        .i_wr_reg  (wr_reg),
        .i_wr_data (wr_data),
        .o_rd_data (rd_data_1)
    );

    reg_file_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_port_2 (
        .i_regs    (w_regs),
        .i_rd_reg  (rd_reg_2),
        .i_wr_fire (w_wr_fire),
        .i_wr_reg  (wr_reg),
        .i_wr_data (wr_data),
        .o_rd_data (rd_data_2)
    );
endmodule

// File: tb/tb_rv32i_reg_file.sv
// tb/tb_rv32i_reg_file.sv - directed and random self-checking bench for rv32i_reg_file
`timescale 1ns/1ps
module tb_rv32i_reg_file;
    import riscv_32i_defs_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    reg_file_intf u_if (.clk(clk));

    rv32i_reg_file u_dut (
        .clk       (clk),
        .rst       (u_if.rst),
        .wr_en     (u_if.wr_en),
        .wr_reg    (u_if.wr_reg),
        .wr_data   (u_if.wr_data),
        .rd_reg_1  (u_if.rd_reg_1),
        .rd_reg_2  (u_if.rd_reg_2),
        .rd_data_1 (u_if.rd_data_1),
        .rd_data_2 (u_if.rd_data_2)
    );

    int unsigned model [32];
    bit          cov_wr [32];
    bit          cov_rd [32];
    bit          cov_en [2];
    int          checks = 0;
    int          errors = 0;

    function automatic int unsigned expect_rd(input int idx);
        if (u_if.rst || idx == 0) return 0;
`ifdef REG_FILE_WR_BYPASS_EN
        if (u_if.wr_en && int'(u_if.wr_reg) == idx) return u_if.wr_data;
`endif
        return model[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_rd1"}, u_if.rd_data_1, expect_rd(int'(u_if.rd_reg_1)));
        check({tag, "_rd2"}, u_if.rd_data_2, expect_rd(int'(u_if.rd_reg_2)));
    endtask

    // Advance one rising edge, applying the architectural write rule to the model.
    task automatic tick();
        @(posedge clk);
        if (u_if.wr_en && !u_if.rst && u_if.wr_reg != 0) model[u_if.wr_reg] = u_if.wr_data;
        #1;
    endtask

    task automatic drive(input logic en, input int wreg, input logic [31:0] wdata,
                         input int r1, input int r2);
        u_if.wr_en    = en;
        u_if.wr_reg   = reg_addr_t'(wreg);
        u_if.wr_data  = wdata;
        u_if.rd_reg_1 = reg_addr_t'(r1);
        u_if.rd_reg_2 = reg_addr_t'(r2);
        #1;
    endtask

    initial begin
        int covered;
        foreach (model[i]) model[i] = 0;
        u_if.rst = 1'b1;
        drive(1'b0, 0, 32'h0, 0, 0);

        // Reset state: every index on both ports reads zero.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, i, 32'hFFFF_FFFF, i, 31 - i);
            check("reset_all", u_if.rd_data_1, 32'h0);
            check("reset_all", u_if.rd_data_2, 32'h0);
        end
        tick();
        @(negedge clk);
        u_if.rst = 1'b0;

        // Write x5, then pulse reset mid-cycle and observe it clear without an edge.
        drive(1'b1, 5, 32'hDEAD_BEEF, 5, 5);
        tick();
        drive(1'b0, 0, 32'h0, 5, 5);
        check("x5_written", u_if.rd_data_1, 32'hDEAD_BEEF);
        u_if.rst = 1'b1;
        foreach (model[i]) model[i] = 0;
        #1;
        check("async_reset", u_if.rd_data_1, 32'h0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 0, 32'h0, i, i);
            check_ports("async_reset_all");
        end
        @(negedge clk);
        u_if.rst = 1'b0;

        // Basic write/read on both ports.
        drive(1'b1, 7, 32'h1234_5678, 0, 0);
        tick();
        drive(1'b0, 0, 32'h0, 7, 7);
        check("basic_rd1", u_if.rd_data_1, 32'h1234_5678);
        check("basic_rd2", u_if.rd_data_2, 32'h1234_5678);

        // Writes to x0 are dropped.
        drive(1'b1, 0, 32'hFFFF_FFFF, 0, 7);
        tick();
        check("x0_protect", u_if.rd_data_1, 32'h0);

        // wr_en low leaves x3 at its reset value.
        drive(1'b0, 3, 32'hA5A5_A5A5, 3, 3);
        tick();
        check("wr_disabled", u_if.rd_data_1, 32'h0);

        // Read-during-write on x9.
        drive(1'b1, 9, 32'h1, 0, 0);
        tick();
        drive(1'b1, 9, 32'h2, 9, 0);
`ifdef REG_FILE_WR_BYPASS_EN
        check("rdw_before", u_if.rd_data_1, 32'h2);
`else
        check("rdw_before", u_if.rd_data_1, 32'h1);
`endif
        tick();
        drive(1'b0, 0, 32'h0, 9, 9);
        check("rdw_after", u_if.rd_data_1, 32'h2);

        // Random regression; the first 32 steps sweep indices so coverage is guaranteed.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (n < 32)
                drive(1'(n % 2), n, $urandom, n, 31 - n);
            else
                drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            cov_wr[u_if.wr_reg]   = 1'b1;
            cov_rd[u_if.rd_reg_1] = 1'b1;
            cov_rd[u_if.rd_reg_2] = 1'b1;
            cov_en[u_if.wr_en]    = 1'b1;
            check_ports("random");
            tick();
            check_ports("random_post");
        end

        covered = 0;
        for (int i = 0; i < 32; i++) covered += int'(cov_wr[i]) + int'(cov_rd[i]);
        covered += int'(cov_en[0]) + int'(cov_en[1]);
        check("coverage", 32'(covered), 32'd66);

        // Final sweep of every register against the model.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 0, 32'h0, i, 31 - i);
            check_ports("final_sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32i_reg_file.md
Name: rv32i_reg_file

Overview:
- RV32I integer register file: 32 general registers x 32 bits, two combinational read ports and one synchronous write port.
- Register x0 is hardwired to zero.
- Sits in the decode/writeback path of the core. Read ports feed the ALU operand paths; the write port is driven from writeback.

Parameters:
- DATA_WIDTH, 32, register width (XLEN).
- NUM_REGS, 32, number of architectural registers.
- ADDR_WIDTH, 5, register index width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high; clears all registers.
- wr_en  input  1  write enable, sampled at the rising edge of clk.
- wr_reg  input  ADDR_WIDTH  destination register index.
- wr_data  input  DATA_WIDTH  write data.
- rd_reg_1  input  ADDR_WIDTH  read port 1 register index.
- rd_reg_2  input  ADDR_WIDTH  read port 2 register index.
- rd_data_1  output  DATA_WIDTH  contents of register rd_reg_1.
- rd_data_2  output  DATA_WIDTH  contents of register rd_reg_2.

Interface bundle: reg_file_intf groups the signals above.
- Takes clk as a port.
- Exposes a monitor modport with all signals as inputs, for coverage and assertions.
- Exposes a driver view for the bench.
- Clock and reset: one clock; reset is asynchronous and active-high.

Behaviour:
- Storage: registers x1..x31, each DATA_WIDTH flops. x0 has no storage.
- Reset: rst=1 immediately (asynchronously) forces x1..x31 to 0, so both read outputs read 0 for any index. Writes are blocked while rst=1. Deassertion takes effect at the next rising edge.
- Reads: purely combinational, zero latency.
  - rd_data_N = reg[rd_reg_N].
  - Index 0 always returns 32'h0000_0000.
  - Both ports are independent; the same index on both ports returns identical data.
- Write: at posedge clk with wr_en=1 and rst=0, reg[wr_reg] <= wr_data. New data is visible on reads after that edge.
- Writes to x0 are silently discarded; x0 reads 0 forever.
- wr_en=0: no state change regardless of wr_reg/wr_data.
- Read-during-write, same index, same cycle: the read returns the OLD value until the edge, i.e. no bypass in the default build.
- Inputs are X-free by contract. Outputs depend only on stored state and read indices, except under the optional feature.
- No handshake, no stall, no internal state machine.

Optional Feature:
- Macro: REG_FILE_WR_BYPASS_EN.
- Defined: each read port forwards wr_data combinationally when wr_en=1, rst=0, wr_reg!=0 and rd_reg_N==wr_reg. A read then sees the value that will be written at the coming edge.
- Undefined (default): no forwarding; read-during-write returns the old stored value as above.
- Index 0 never forwards in either build.

Decomposition:
- Shared package riscv_32i_defs_pkg:
  - XLEN=32, NUM_REGS=32, REG_ADDR_WIDTH=5.
  - word_t (logic [XLEN-1:0]) and reg_addr_t (logic [REG_ADDR_WIDTH-1:0]).
  - ZERO_REG constant (5'd0).
- Sub-module reg_file_rd_port, instantiated twice. It performs the index-to-data mux, x0 zeroing and the optional bypass compare.
- Concurrent assertions live in a separate bound checker, reg_file_assert:
  - x0 reads 0.
  - No write when wr_en=0.
  - Outputs known after reset.

Test Plan:
- Reset: pulse rst mid-cycle after writing x5=32'hDEAD_BEEF -> rd_data_1 for rd_reg_1=5 becomes 0 without waiting for a clock edge; all 32 indices read 0.
- Basic write/read: wr_en=1, wr_reg=7, wr_data=32'h1234_5678, clock, then rd_reg_1=7, rd_reg_2=7 -> both outputs 32'h1234_5678.
- x0 protection: wr_en=1, wr_reg=0, wr_data=32'hFFFF_FFFF, clock -> rd_reg_1=0 reads 32'h0.
- Write disabled: wr_en=0, wr_reg=3, wr_data=32'hA5A5_A5A5, clock -> x3 keeps its prior value, e.g. 0 after reset.
- Read-during-write: x9=32'h1, then wr_en=1, wr_reg=9, wr_data=32'h2 with rd_reg_1=9 -> 32'h1 before the edge and 32'h2 after it (default build). With REG_FILE_WR_BYPASS_EN defined -> 32'h2 before the edge.
- Random regression: 1000 random transactions checked against a reference array model after each combinational settle, with coverage of all wr_reg/rd_reg indices and wr_en values -> zero mismatches.
